// File: rtl/axi4_rd_burst_sequencer.sv
// AXI4 read command sequencer: splits one linear read into INCR bursts
// bounded by MAX_BURST_LEN and 4 KB pages, with an outstanding-burst limit.
module axi4_rd_burst_sequencer #(
    parameter int DATA_BYTES      = 4,
    parameter int ADDR_BYTES      = 4,
    parameter int NUM_ID_BITS     = 4,
    parameter int MAX_BURST_LEN   = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [ADDR_BYTES*8-1:0]   cmd_addr,
    input  logic [15:0]               cmd_beats,
    input  logic [NUM_ID_BITS-1:0]    cmd_id,
    output logic                      arvalid,
    input  logic                      arready,
    output logic [ADDR_BYTES*8-1:0]   araddr,
    output logic [7:0]                arlen,
    output logic [2:0]                arsize,
    output logic [1:0]                arburst,
    output logic [NUM_ID_BITS-1:0]    arid,
    input  logic                      rvalid,
    input  logic                      rready,
    input  logic                      rlast,
    input  logic [1:0]                rresp,
    output logic                      busy,
    output logic                      done_valid,
    output logic                      done_err
);

    localparam int AW   = ADDR_BYTES * 8;
    localparam int SIZE = $clog2(DATA_BYTES);
    localparam logic [AW-1:0] LOW_MASK = AW'(DATA_BYTES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]             state_q, state_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic                   arvalid_q, arvalid_d;
    logic [AW-1:0]          araddr_q, araddr_d;
    logic [7:0]             arlen_q, arlen_d;
    logic [NUM_ID_BITS-1:0] arid_q, arid_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [15:0]            rem_q, rem_d;
    logic [3:0]             out_q, out_d;
    logic                   err_q, err_d;

    logic                   ar_hs, r_hs, r_done, try_load;
    logic [AW-1:0]          base_addr;
    logic [15:0]            base_rem;
    logic [12:0]            bnd_beats;
    logic [15:0]            burst;

    wire unused_rresp = rresp[0];

    // addr_q/rem_q track the next burst not yet placed on AR; they
    // advance when a burst is loaded into the AR registers.
    always_comb begin
        state_d     = state_q;
        arvalid_d   = arvalid_q;
        araddr_d    = araddr_q;
        arlen_d     = arlen_q;
        arid_d      = arid_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        err_d       = err_q;
        try_load    = 1'b0;
        base_addr   = addr_q;
        base_rem    = rem_q;

        ar_hs  = arvalid_q & arready;
        r_hs   = rvalid & rready & ((state_q == S_ISSUE) || (state_q == S_DRAIN));
        r_done = r_hs & rlast & (out_q != 4'd0);

        out_d = out_q;
        if (ar_hs && !r_done) begin
            out_d = out_q + 4'd1;
        end else if (!ar_hs && r_done) begin
            out_d = out_q - 4'd1;
        end

        if (r_hs && rresp[1]) begin
            err_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    base_addr = cmd_addr & ~LOW_MASK;
                    base_rem  = cmd_beats;
                    addr_d    = base_addr;
                    rem_d     = cmd_beats;
                    arid_d    = cmd_id;
                    err_d     = 1'b0;
                    try_load  = 1'b1;
                    state_d   = (cmd_beats == 16'd0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                try_load = 1'b1;
                if (rem_q == 16'd0 && (!arvalid_q || ar_hs)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_q == 4'd0) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        bnd_beats = (13'h1000 - {1'b0, base_addr[11:0]}) >> SIZE;
        burst = base_rem;
        if (burst > 16'(MAX_BURST_LEN)) begin
            burst = 16'(MAX_BURST_LEN);
        end
        if (burst > {3'b000, bnd_beats}) begin
            burst = {3'b000, bnd_beats};
        end

        if (try_load && base_rem != 16'd0 && (!arvalid_q || ar_hs)
            && out_d < 4'(MAX_OUTSTANDING)) begin
            arvalid_d = 1'b1;
            araddr_d  = base_addr;
            arlen_d   = 8'(burst - 16'd1);
            addr_d    = base_addr + (AW'(burst) << SIZE);
            rem_d     = base_rem - burst;
        end else if (ar_hs) begin
            arvalid_d = 1'b0;
        end

        cmd_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b0;
            arvalid_q   <= 1'b0;
            araddr_q    <= '0;
            arlen_q     <= '0;
            arid_q      <= '0;
            addr_q      <= '0;
            rem_q       <= '0;
            out_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            arvalid_q   <= arvalid_d;
            araddr_q    <= araddr_d;
            arlen_q     <= arlen_d;
            arid_q      <= arid_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            out_q       <= out_d;
            err_q       <= err_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign arvalid    = arvalid_q;
    assign araddr     = araddr_q;
    assign arlen      = arlen_q;
    assign arid       = arid_q;
    assign arsize     = 3'(SIZE);
    assign arburst    = 2'b01;
    assign busy       = (state_q != S_IDLE);
    assign done_valid = (state_q == S_DONE);
    assign done_err   = (state_q == S_DONE) & err_q;

endmodule

// File: tb/tb_axi4_rd_burst_sequencer.sv
// Bench for axi4_rd_burst_sequencer: directed and random commands against
// a burst-list model and a simple AXI read slave model.
module tb_axi4_rd_burst_sequencer;

    localparam int MAXO = 4;
    localparam int MAXB = 16;
    localparam int DB   = 4;

    logic        aclk = 1'b0;
    logic        areset;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_beats;
    logic [3:0]  cmd_id;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [3:0]  arid;
    logic        rvalid, rready, rlast;
    logic [1:0]  rresp;
    logic        busy, done_valid, done_err;

    always #5 aclk = ~aclk;

    axi4_rd_burst_sequencer dut (
        .aclk(aclk), .areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_beats(cmd_beats), .cmd_id(cmd_id),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .arlen(arlen), .arsize(arsize), .arburst(arburst), .arid(arid),
        .rvalid(rvalid), .rready(rready), .rlast(rlast), .rresp(rresp),
        .busy(busy), .done_valid(done_valid), .done_err(done_err)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] exp_addr[$];
    logic [7:0]  exp_len[$];
    logic [3:0]  exp_id;
    int          rq[$];
    int          rcnt = 0, infl = 0, ar_count = 0, rhs_cnt = 0;
    int          err_at = -1;
    int          cyc = 0, zero_cyc = 0;
    bit          err_exp = 0, r_en = 1;
    int          ar_pct = 100, r_pct = 100, rr_pct = 100, err_pct = 0;
    logic        prev_av, prev_ar, prev_rst;
    logic [31:0] prev_addr;
    logic [7:0]  prev_len;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive_r();
        if (r_en && rq.size() > 0 && $urandom_range(99) < r_pct) begin
            rvalid = 1'b1;
            rlast  = (rcnt == rq[0] - 1);
            if (rhs_cnt == err_at)
                rresp = 2'b10;
            else if ($urandom_range(99) < err_pct)
                rresp = {1'b1, 1'($urandom_range(1))};
            else
                rresp = {1'b0, 1'($urandom_range(1))};
        end else begin
            rvalid = 1'b0;
            rlast  = 1'b0;
            rresp  = 2'b00;
        end
        rready = ($urandom_range(99) < rr_pct);
    endtask

    // One clock: account for handshakes seen at the coming edge, then
    // check AR hold behaviour and redraw the random channel inputs.
    task automatic tick();
        bit hs_ar, hs_r;
        hs_ar = arvalid && arready && !areset;
        hs_r  = rvalid && rready && !areset;
        if (arvalid && !areset) chk("ar_limit", 32'(infl < MAXO), 1);
        if (hs_ar) begin
            ar_count++;
            if (exp_addr.size() == 0) begin
                chk("ar_unexpected", exp_addr.size(), 1);
            end else begin
                chk("araddr", araddr, exp_addr[0]);
                chk("arlen", arlen, exp_len[0]);
                chk("arid", arid, exp_id);
                chk("arsize", arsize, 2);
                chk("arburst", arburst, 1);
                void'(exp_addr.pop_front());
                void'(exp_len.pop_front());
            end
            rq.push_back(int'(arlen) + 1);
            infl++;
        end
        if (hs_r && rq.size() > 0) begin
            rhs_cnt++;
            if (rresp[1]) err_exp = 1;
            if (rlast) begin
                void'(rq.pop_front());
                rcnt = 0;
                infl--;
                if (infl == 0) zero_cyc = cyc + 1;
            end else begin
                rcnt++;
            end
        end
        prev_av   = arvalid;
        prev_ar   = arready;
        prev_rst  = areset;
        prev_addr = araddr;
        prev_len  = arlen;
        @(posedge aclk);
        @(negedge aclk);
        cyc++;
        if (prev_av && !prev_ar && !prev_rst) begin
            chk("ar_hold_valid", arvalid, 1);
            chk("ar_hold_addr", araddr, prev_addr);
            chk("ar_hold_len", arlen, prev_len);
        end
        arready = ($urandom_range(99) < ar_pct);
        drive_r();
    endtask

    task automatic plan_cmd(logic [31:0] addr, int beats, logic [3:0] id);
        logic [31:0] a;
        int rem, b, bnd;
        exp_id = id;
        a = addr & ~32'h3;
        rem = beats;
        while (rem > 0) begin
            bnd = (4096 - int'(a & 32'hFFF)) / DB;
            b = rem;
            if (b > MAXB) b = MAXB;
            if (b > bnd) b = bnd;
            exp_addr.push_back(a);
            exp_len.push_back(8'(b - 1));
            a = a + 32'(b * DB);
            rem -= b;
        end
    endtask

    task automatic start_cmd(logic [31:0] addr, int beats, logic [3:0] id);
        int n = 0;
        while (!cmd_ready && n < 100) begin
            tick();
            n++;
        end
        chk("cmd_ready_wait", cmd_ready, 1);
        plan_cmd(addr, beats, id);
        err_exp  = 0;
        ar_count = 0;
        rhs_cnt  = 0;
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_beats = 16'(beats);
        cmd_id    = id;
        tick();
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;
        cmd_beats = 16'($urandom);
        cmd_id    = 4'($urandom);
        chk("busy_after_cmd", busy, 1);
        if (beats == 0) begin
            chk("zero_done", done_valid, 1);
            chk("zero_no_ar", arvalid, 0);
        end else begin
            chk("ar_rise", arvalid, 1);
        end
    endtask

    task automatic finish_cmd(input bit had_beats, output logic e);
        int n = 0;
        while (!done_valid && n < 5000) begin
            tick();
            n++;
        end
        chk("done_seen", done_valid, 1);
        chk("done_err", done_err, 32'(err_exp));
        chk("ar_all_issued", exp_addr.size(), 0);
        chk("inflight_zero", infl, 0);
        if (had_beats) chk("done_latency", cyc - zero_cyc, 1);
        e = done_err;
        tick();
        chk("done_pulse", done_valid, 0);
        chk("ready_after_done", cmd_ready, 1);
    endtask

    initial begin
        logic        e;
        logic [31:0] ra;
        int          rb;

        areset = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr = '0;
        cmd_beats = '0;
        cmd_id = '0;
        arready = 1'b0;
        rvalid = 1'b0;
        rready = 1'b0;
        rlast = 1'b0;
        rresp = 2'b00;
        repeat (3) @(negedge aclk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done_valid", done_valid, 0);
        chk("rst_done_err", done_err, 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_arlen", arlen, 0);
        chk("rst_arid", arid, 0);
        areset = 1'b0;
        tick();
        chk("ready_after_rst", cmd_ready, 1);

        // single burst
        start_cmd(32'h000, 10, 4'h4);
        finish_cmd(1, e);

        // length split
        start_cmd(32'h100, 40, 4'h5);
        finish_cmd(1, e);

        // 4 KB crossing
        start_cmd(32'hFF8, 8, 4'hA);
        finish_cmd(1, e);

        // address wrap at top of space
        start_cmd(32'hFFFF_FFF0, 20, 4'h1);
        finish_cmd(1, e);

        // outstanding limit, then one completion frees a slot
        r_en = 0;
        start_cmd(32'h000, 100, 4'h3);
        repeat (12) tick();
        chk("os_ar_count", ar_count, 4);
        chk("os_arvalid_low", arvalid, 0);
        rcnt = rq[0] - 1;
        rvalid = 1'b1;
        rready = 1'b1;
        rlast = 1'b1;
        rresp = 2'b00;
        tick();
        chk("os_fifth_valid", arvalid, 1);
        chk("os_fifth_addr", araddr, 32'h100);
        r_en = 1;
        finish_cmd(1, e);

        // AR stall plus error on a middle beat
        ar_pct = 0;
        err_at = 7;
        start_cmd(32'h200, 20, 4'h9);
        repeat (5) tick();
        chk("stall_valid", arvalid, 1);
        chk("stall_addr", araddr, 32'h200);
        chk("stall_len", arlen, 15);
        ar_pct = 100;
        finish_cmd(1, e);
        chk("err_sticky", e, 1);
        err_at = -1;
        start_cmd(32'h300, 5, 4'h2);
        finish_cmd(1, e);
        chk("err_cleared", e, 0);

        // zero-beat command
        start_cmd(32'h400, 0, 4'h7);
        finish_cmd(0, e);

        // reset during ISSUE, then a stray rlast in IDLE
        r_en = 0;
        start_cmd(32'h000, 100, 4'h1);
        repeat (3) tick();
        arready = 1'b0;
        areset = 1'b1;
        tick();
        chk("mid_rst_arvalid", arvalid, 0);
        chk("mid_rst_busy", busy, 0);
        areset = 1'b0;
        exp_addr.delete();
        exp_len.delete();
        rq.delete();
        infl = 0;
        rcnt = 0;
        rvalid = 1'b1;
        rready = 1'b1;
        rlast = 1'b1;
        tick();
        chk("stray_ready", cmd_ready, 1);
        start_cmd(32'h040, 100, 4'h6);
        repeat (12) tick();
        chk("post_rst_ar_count", ar_count, 4);
        r_en = 1;
        finish_cmd(1, e);

        // randomized commands
        err_pct = 10;
        for (int i = 0; i < 25; i++) begin
            ar_pct = $urandom_range(100, 30);
            r_pct  = $urandom_range(100, 30);
            rr_pct = $urandom_range(100, 30);
            ra = $urandom;
            if ($urandom_range(1) == 1)
                ra = (ra & ~32'hFFF) | (32'hFC0 + 32'($urandom_range(63)));
            rb = ($urandom_range(3) == 0) ? $urandom_range(3) : $urandom_range(120);
            start_cmd(ra, rb, 4'($urandom));
            finish_cmd(rb != 0, e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
